// File: rtl/dlsc_mt9v032_align.sv
// dlsc_mt9v032_align: IODELAY calibration sequencer and phase-vote tap tracker for one mt9v032 LVDS lane (start/stop/pd_*/bitslip_*/iod_busy in; iod_* pulses, bitslip_mask, locked, tap_offset, fault, limit_hit out)
module dlsc_mt9v032_align #(
  parameter int PD_BITS   = 4,
  parameter int PD_THRESH = 6,
  parameter int TAP_LIMIT = 20,
  parameter int ERR_LIMIT = 4,
  parameter int BUSY_TO   = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pd_valid,
  input  logic       pd_inc,
  input  logic       bitslip_okay,
  input  logic       bitslip_error,
  input  logic       iod_busy,
  output logic       iod_rst_master,
  output logic       iod_rst_slave,
  output logic       iod_cal_master,
  output logic       iod_cal_slave,
  output logic       iod_en,
  output logic       iod_inc,
  output logic       bitslip_mask,
  output logic       locked,
  output logic [7:0] tap_offset,
  output logic       fault,
  output logic       limit_hit
);
  typedef enum logic [3:0] {IDLE, CAL, CALW, RST, RSTW, TRACK, STEP, STEPW, FAULT} state_t;
  localparam int CW = $clog2(BUSY_TO + 2);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam logic signed [PD_BITS-1:0] ONE = PD_BITS'(1);
  localparam logic signed [PD_BITS-1:0] ACC_MAX = PD_BITS'((1 << (PD_BITS - 1)) - 1);
  localparam logic signed [PD_BITS-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [PD_BITS-1:0] THR = PD_BITS'(PD_THRESH);
  localparam logic signed [5:0] TAP_L = 6'(TAP_LIMIT);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [PD_BITS-1:0] acc_q, acc_d, acc_v;
  logic signed [5:0] tap_q, tap_d;
  logic [EW-1:0] err_q, err_d, err_n;
  logic dir_q, dir_d, fault_q, fault_d, limit_q, limit_d, locked_q;
  logic trk, wait_st, busy_done, timeout, reach, allow;
  assign trk = state_q inside {TRACK, STEP, STEPW};
  assign wait_st = state_q inside {CALW, RSTW, STEPW};
  assign busy_done = cnt_q >= CW'(2) && !iod_busy;
  assign timeout = cnt_q == CW'(BUSY_TO + 1);
  assign acc_v = pd_inc ? (acc_q == ACC_MAX ? acc_q : acc_q + ONE)
                        : (acc_q == ACC_MIN ? acc_q : acc_q - ONE);
  assign reach = acc_v == THR || acc_v == -THR;
  assign allow = pd_inc ? tap_q < TAP_L : tap_q > -TAP_L;
  assign err_n = bitslip_okay ? '0 : bitslip_error ? err_q + EW'(1) : err_q;
  assign iod_cal_master = state_q == CAL;
  assign iod_cal_slave = state_q == CAL;
  assign iod_rst_master = state_q == RST;
  assign iod_rst_slave = state_q == RST;
  assign iod_en = state_q == STEP;
  assign iod_inc = state_q == STEP && dir_q;
  assign bitslip_mask = !trk;
  assign locked = locked_q;
  assign tap_offset = {{2{tap_q[5]}}, tap_q};
  assign fault = fault_q;
  assign limit_hit = limit_q;
  always_comb begin
    state_d = state_q;
    cnt_d = wait_st ? cnt_q + CW'(1) : '0;
    acc_d = acc_q;
    tap_d = tap_q;
    err_d = '0;
    dir_d = dir_q;
    limit_d = limit_q;
    fault_d = fault_q | (wait_st && !busy_done && timeout);
    case (state_q)
      IDLE, FAULT: ;
      CAL: state_d = CALW;
      CALW: state_d = busy_done ? RST : timeout ? FAULT : CALW;
      RST: begin
        tap_d = '0;
        state_d = RSTW;
      end
      RSTW: state_d = busy_done ? TRACK : timeout ? FAULT : RSTW;
      TRACK: if (pd_valid) begin
        acc_d = reach ? '0 : acc_v;
        state_d = reach && allow ? STEP : TRACK;
        dir_d = reach && allow ? pd_inc : dir_q;
        limit_d = limit_q | (reach && !allow);
      end
      STEP: begin
        tap_d = tap_q + (dir_q ? 6'sd1 : -6'sd1);
        state_d = STEPW;
      end
      STEPW: state_d = busy_done ? TRACK : timeout ? FAULT : STEPW;
      default: state_d = IDLE;
    endcase
    if (trk) begin
      err_d = err_n;
      if (err_n == EW'(ERR_LIMIT)) begin
        state_d = CAL;
        acc_d = '0;
        err_d = '0;
        tap_d = '0;
      end
    end else acc_d = '0;
    if (start && state_q inside {IDLE, TRACK, STEP, STEPW, FAULT}) begin
      state_d = CAL;
      fault_d = 1'b0;
      limit_d = 1'b0;
    end
    if (stop) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      tap_q <= '0;
      err_q <= '0;
      dir_q <= 1'b0;
      fault_q <= 1'b0;
      limit_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      tap_q <= tap_d;
      err_q <= err_d;
      dir_q <= dir_d;
      fault_q <= fault_d;
      limit_q <= limit_d;
      locked_q <= trk && bitslip_okay;
    end
  end
endmodule
